// File: rtl/run_ctrl_if.sv
// Handshake bundle between the run controller and its environment (PC + instruction decode).
// The slave side is the controller; the master side drives start and instruction fields.
interface run_ctrl_if #(
  parameter int D     = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic [2:0]       opcode;
  logic [5:0]       imm;
  logic             zero_flag;
  logic             halt;
  logic             pc_start;
  logic             jump_en;
  logic [D-1:0]     jump_target;
  logic [2:0]       jump_op;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       branch_count;

  modport master (
    output start, opcode, imm, zero_flag, halt,
    input  pc_start, jump_en, jump_target, jump_op, busy, done, timeout,
           cycle_count, branch_count
  );

  modport slave (
    input  start, opcode, imm, zero_flag, halt,
    output pc_start, jump_en, jump_target, jump_op, busy, done, timeout,
           cycle_count, branch_count
  );
endinterface

// File: rtl/run_ctrl.sv
// Run-sequencing and branch-resolution controller for the program counter.
// Gates a run from start to halt/timeout and resolves absolute/relative branches on the zero flag.
module run_ctrl #(
  parameter int D          = 10,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 5000
) (
  input  logic      clk,
  input  logic      reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [7:0]       branch_count_q;
  logic             timeout_q;
  logic             pc_start_q;
  logic             busy_q;
  logic             done_q;

  logic             in_run;
  logic             is_branch;
  logic             take_branch;
  logic [D-1:0]     target_c;

  assign in_run      = (state_q == RUN);
  assign is_branch   = (bus.opcode == 3'b111) || (bus.opcode == 3'b001);
  assign take_branch = in_run && !bus.halt && bus.zero_flag && is_branch;

  always_comb begin
    target_c = '0;
    if (in_run) begin
      case (bus.opcode)
        3'b111:  target_c = {{(D-6){1'b0}}, bus.imm};
        3'b001:  target_c = {{(D-6){bus.imm[5]}}, bus.imm};
        default: target_c = '0;
      endcase
    end else begin
      target_c = '0;
    end
  end

  // Counters are cleared on entry to CLEAR so the CLEAR cycle already reports a fresh run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cycle_count_q  <= '0;
      branch_count_q <= 8'd0;
      timeout_q      <= 1'b0;
      pc_start_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q        <= CLEAR;
            cycle_count_q  <= '0;
            branch_count_q <= 8'd0;
            timeout_q      <= 1'b0;
            pc_start_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
          end
        end
        CLEAR: begin
          state_q        <= RUN;
          cycle_count_q  <= '0;
          branch_count_q <= 8'd0;
          timeout_q      <= 1'b0;
          pc_start_q     <= 1'b0;
          busy_q         <= 1'b1;
          done_q         <= 1'b0;
        end
        RUN: begin
          cycle_count_q <= cycle_count_q + CNT_W'(1);
          if (take_branch && (branch_count_q != 8'hFF)) begin
            branch_count_q <= branch_count_q + 8'd1;
          end
          // Halt takes priority over budget exhaustion in the same cycle.
          if (bus.halt || (cycle_count_q == LAST_CYCLE)) begin
            state_q    <= DONE;
            timeout_q  <= !bus.halt;
            pc_start_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          pc_start_q <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_start     = pc_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.branch_count = branch_count_q;
  assign bus.jump_en      = take_branch;
  assign bus.jump_target  = target_c;
  assign bus.jump_op      = in_run ? bus.opcode : 3'b000;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a small PC model driven by the controller outputs.
module tb_run_ctrl;

  localparam int D     = 10;
  localparam int CNT_W = 16;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [D-1:0] pc_m;

  run_ctrl_if #(.D(D), .CNT_W(CNT_W)) bus ();

  run_ctrl #(.D(D), .CNT_W(CNT_W), .MAX_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference program counter: clear on pc_start, jump absolute/relative, else increment.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_m <= '0;
    end else if (bus.pc_start) begin
      pc_m <= '0;
    end else if (bus.jump_en && bus.jump_op == 3'b111) begin
      pc_m <= bus.jump_target;
    end else if (bus.jump_en && bus.jump_op == 3'b001) begin
      pc_m <= pc_m + bus.jump_target;
    end else begin
      pc_m <= pc_m + 10'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.opcode     = 3'b000;
    bus.imm        = 6'd0;
    bus.zero_flag  = 1'b0;
    bus.halt       = 1'b0;
    #12;
    chk("rst_pc_start", 32'(bus.pc_start), 32'd1);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    chk("rst_done",     32'(bus.done), 32'd0);
    chk("rst_jump_en",  32'(bus.jump_en), 32'd0);
    chk("rst_target",   32'(bus.jump_target), 32'd0);
    chk("rst_jump_op",  32'(bus.jump_op), 32'd0);
    chk("rst_cycles",   32'(bus.cycle_count), 32'd0);
    chk("rst_branches", 32'(bus.branch_count), 32'd0);
    chk("rst_timeout",  32'(bus.timeout), 32'd0);
    reset = 1'b0;

    tick();                       // still IDLE
    chk("idle_pc_start", 32'(bus.pc_start), 32'd1);
    bus.start = 1'b1;
    tick();                       // CLEAR
    bus.start = 1'b0;
    chk("clear_pc_start", 32'(bus.pc_start), 32'd1);
    chk("clear_busy",     32'(bus.busy), 32'd1);
    tick();                       // RUN cycle 1
    chk("run1_pc_start", 32'(bus.pc_start), 32'd0);
    chk("run1_pc",       32'(pc_m), 32'd0);
    chk("run1_cycles",   32'(bus.cycle_count), 32'd0);
    tick();                       // RUN cycle 2
    chk("run2_pc", 32'(pc_m), 32'd1);

    bus.opcode = 3'b111; bus.imm = 6'd20; bus.zero_flag = 1'b1;
    #1;
    chk("abs_jump_en", 32'(bus.jump_en), 32'd1);
    chk("abs_target",  32'(bus.jump_target), 32'd20);
    chk("abs_jump_op", 32'(bus.jump_op), 32'd7);
    tick();                       // RUN cycle 3
    chk("abs_pc",       32'(pc_m), 32'd20);
    chk("abs_branches", 32'(bus.branch_count), 32'd1);
    chk("abs_cycles",   32'(bus.cycle_count), 32'd2);

    bus.zero_flag = 1'b0;
    #1;
    chk("abs_nz_jump_en", 32'(bus.jump_en), 32'd0);
    tick();                       // RUN cycle 4
    chk("nz_pc", 32'(pc_m), 32'd21);

    bus.opcode = 3'b001; bus.imm = 6'b111101; bus.zero_flag = 1'b1; bus.start = 1'b1;
    #1;
    chk("rel_jump_en", 32'(bus.jump_en), 32'd1);
    chk("rel_target",  32'(bus.jump_target), 32'h3FD);
    tick();                       // RUN cycle 5, start must be ignored
    bus.start = 1'b0;
    chk("rel_pc",        32'(pc_m), 32'd18);
    chk("start_ign_busy", 32'(bus.busy), 32'd1);
    chk("start_ign_pcs",  32'(bus.pc_start), 32'd0);
    chk("rel_branches",   32'(bus.branch_count), 32'd2);

    bus.halt = 1'b1; bus.opcode = 3'b111; bus.imm = 6'd20; bus.zero_flag = 1'b1;
    #1;
    chk("halt_jump_en", 32'(bus.jump_en), 32'd0);
    tick();                       // DONE
    bus.halt = 1'b0;
    #1;
    chk("halt_done",     32'(bus.done), 32'd1);
    chk("halt_busy",     32'(bus.busy), 32'd0);
    chk("halt_timeout",  32'(bus.timeout), 32'd0);
    chk("halt_cycles",   32'(bus.cycle_count), 32'd5);
    chk("done_jump_en",  32'(bus.jump_en), 32'd0);
    chk("done_target",   32'(bus.jump_target), 32'd0);
    chk("done_jump_op",  32'(bus.jump_op), 32'd0);

    bus.opcode = 3'b000; bus.zero_flag = 1'b0; bus.start = 1'b1;
    tick();                       // CLEAR
    bus.start = 1'b0;
    tick();                       // RUN cycle 1
    for (int i = 0; i < 7; i++) tick();
    chk("to_run8_busy",   32'(bus.busy), 32'd1);
    chk("to_run8_cycles", 32'(bus.cycle_count), 32'd7);
    tick();                       // DONE by timeout
    chk("to_done",    32'(bus.done), 32'd1);
    chk("to_timeout", 32'(bus.timeout), 32'd1);
    chk("to_cycles",  32'(bus.cycle_count), 32'd8);
    tick();                       // DONE holds
    chk("to_hold_timeout", 32'(bus.timeout), 32'd1);
    chk("to_hold_cycles",  32'(bus.cycle_count), 32'd8);

    bus.start = 1'b1;
    tick();                       // CLEAR
    bus.start = 1'b0;
    tick();                       // RUN cycle 1
    chk("relaunch_timeout", 32'(bus.timeout), 32'd0);
    chk("relaunch_cycles",  32'(bus.cycle_count), 32'd0);
    chk("relaunch_branch",  32'(bus.branch_count), 32'd0);

    bus.opcode = 3'b111; bus.imm = 6'd5; bus.zero_flag = 1'b1;
    tick();                       // RUN cycle 2, one branch counted
    chk("pre_rst_branches", 32'(bus.branch_count), 32'd1);
    chk("pre_rst_jump_en",  32'(bus.jump_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy",     32'(bus.busy), 32'd0);
    chk("midrst_pc_start", 32'(bus.pc_start), 32'd1);
    chk("midrst_jump_en",  32'(bus.jump_en), 32'd0);
    chk("midrst_cycles",   32'(bus.cycle_count), 32'd0);
    chk("midrst_branches", 32'(bus.branch_count), 32'd0);
    #2;
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
